// File: rtl/seq_add_sub.sv
`timescale 1ns/1ps
// Digit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands DIGIT bits per clock.
// Latency: exactly N = WIDTH/DIGIT edges from the accepting edge to the one-cycle done pulse.
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE (back-to-back).
module seq_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operands are held pre-conditioned: in subtract mode b is inverted and
    // the carry-in inverted, so the datapath is always a plain adder.
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic                   carry;
    logic                   a_msb;
    logic                   b_msb;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       acc;

    logic                   accept;
    logic                   last;
    logic [DIGIT:0]         slice_sum;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_nxt;

    assign accept    = start && (state != RUN);
    assign last      = (cnt == LAST);
    // Low slice of the shifting operands plus the carry from the previous slice.
    assign slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // New slice enters at the top; after N slices the accumulator is LSB-aligned.
    assign acc_cat   = {slice_sum[DIGIT-1:0], acc};
    assign acc_nxt   = acc_cat[WIDTH+DIGIT-1:DIGIT];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: RUN lasts exactly N edges, DONE lasts one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand capture, slice-by-slice accumulation and result update on the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= cin ^ sub;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1] ^ sub;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            carry <= slice_sum[DIGIT];
            acc   <= acc_nxt;
            cnt   <= cnt + 1'b1;
            if (last) begin
                s    <= acc_nxt;
                cout <= slice_sum[DIGIT];
                ovf  <= (a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

// File: doc/seq_add_sub.md
SEQ_ADD_SUB -- requirements
Module: seq_add_sub

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 SHALL provide parameter DIGIT, default 4, bits processed per clock; WIDTH % DIGIT == 0, 1 <= DIGIT <= WIDTH.
REQ-003 SHALL define localparam N = WIDTH/DIGIT, the number of processing cycles.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin an operation; sampled on rising edge.
REQ-007 a  input  WIDTH  operand A, captured on accepted start.
REQ-008 b  input  WIDTH  operand B, captured on accepted start.
REQ-009 cin  input  1  carry-in (add) / borrow-in (sub), captured on accepted start.
REQ-010 sub  input  1  mode, captured on accepted start: 0 = add, 1 = subtract.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse marking result valid.
REQ-013 s  output  WIDTH  result.
REQ-014 cout  output  1  carry-out (add) / not-borrow (sub).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 Start is accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands or progress.
- On acceptance (edge 0): latch a, b, cin, sub; clear the digit counter; go to RUN; busy=1 from that edge.
REQ-018 Add: {cout,s} = a + b + cin, computed modulo 2^(WIDTH+1).
REQ-019 Sub: {cout,s} = a + ~b + ~cin, i.e. s = a - b - cin mod 2^WIDTH; cout=1 means no borrow.
REQ-020 ovf SHALL be 1 iff the operand sign bits (a and effective b, where effective b is ~b in sub) are equal and the s sign bit differs from them.
REQ-021 In RUN, each edge SHALL process one DIGIT-bit slice, least-significant first, carrying the registered carry between slices.
- Edges 1..N process slices 0..N-1.
- The counter wraps only via the FSM; no slice is processed twice.
REQ-022 On edge N: go to DONE; done=1, busy=0; update s, cout and ovf simultaneously.
REQ-023 s, cout and ovf SHALL hold their last result until the next completion; they never show partial sums during RUN.
REQ-024 From DONE: the next edge goes to IDLE (done=0), or to RUN if start=1 (back-to-back, done=0, busy=1).
REQ-025 Total latency SHALL be exactly N edges from the accepting edge to done=1; throughput is one operation per N+1 cycles back-to-back.
REQ-026 Operand inputs changing during RUN SHALL NOT affect the result.
REQ-027 With DIGIT == WIDTH (N=1), behaviour SHALL follow the same rules with a one-edge RUN.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, s=0, cout=0, ovf=0, and clear the counter and latched operands.
REQ-029 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows release.
REQ-030 After rst_n rises, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8, DIGIT=4, N=2)
REQ-031 Add a=5, b=4, cin=0, sub=0 -> done exactly 2 edges after acceptance; s=9, cout=0, ovf=0; busy high for 2 cycles.
REQ-032 Add a=200, b=100, cin=1 -> s=45, cout=1, ovf=0.
REQ-033 Add a=127, b=1, cin=0 -> s=128, cout=0, ovf=1. Sub a=3, b=9, cin=0 -> s=250, cout=0, ovf=0. Sub a=9, b=3, cin=1 -> s=5, cout=1, ovf=0.
REQ-034 Start a=5, b=4, then start with a=1, b=1 one edge later (in RUN) -> second start ignored; single done with s=9.
REQ-035 Back-to-back: start held high across DONE with a=3, b=9, cin=1 -> done pulses for the first op, busy=1 on the next edge, second done gives s=13; s keeps the first result until then.
REQ-036 rst_n pulsed low after edge 1 of RUN -> outputs zero immediately; no done after release; a fresh add of 8+9 then gives s=17.
